wb_retire_unit: RTL and testbench
=================================

Name: wb_retire_unit

Overview:
Writeback/retire stage that consumes the MEM/WB pipeline register outputs, the receiving end of that interface. Per cycle it:
- selects and sign/zero-extends the writeback data;
- drives the register-file write port, suppressing writes to r0;
- holds a registered WB-to-ID forwarding entry;
- counts retired instructions;
- runs the halt-drain FSM that raises the final HALT to the testbench.

Parameters:
DATA_W, 32, datapath width
ADDR_W, 5, register address width
CNT_W, 32, retired-instruction counter width
HALT_DRAIN, 2, idle cycles between HALT retire and HALT_OUT assertion (0 allowed)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
RWSrc  in  2  writeback select: 00 ALUOUT, 01 load data, 10 ADD_PC (link), 11 zero
OPSrc  in  2  load extension: 00 word, 01 byte signed, 10 half signed, 11 byte unsigned
RF_WE  in  1  instruction writes register file
NUM_CHECK  in  1  valid instruction in WB (counts as retired)
HALT  in  1  instruction in WB is halt
ALUOUT_MEMWB  in  DATA_W  ALU result
ADD_PC_MEMWB  in  DATA_W  PC+4 link value
D_MEM_DI_OUT  in  DATA_W  raw load data
WA_MEMWB  in  ADDR_W  destination register
RF_WE_OUT  out  1  register-file write enable
RF_WA  out  ADDR_W  register-file write address
RF_WD  out  DATA_W  register-file write data
FWD_VALID  out  1  forwarding entry valid (registered)
FWD_WA  out  ADDR_W  forwarding address (registered)
FWD_WD  out  DATA_W  forwarding data (registered)
NUM_INST  out  CNT_W  retired-instruction count
HALT_OUT  out  1  processor halted, sticky until RST

Behaviour:
- Reset values:
  - state RUN;
  - NUM_INST=0, HALT_OUT=0;
  - FWD_VALID=0, FWD_WA=0, FWD_WD=0.
  - RF_WE_OUT is forced 0 while RST is high.
- Extension:
  - byte = D_MEM_DI_OUT[7:0]; half = D_MEM_DI_OUT[15:0].
  - Signed modes replicate bit 7 or bit 15; unsigned zero-fills.
  - OPSrc applies only when RWSrc=01.
- Write path (combinational, same cycle):
  - RF_WD = selected value.
  - RF_WA = WA_MEMWB.
  - RF_WE_OUT = RF_WE & NUM_CHECK & ~HALT & (WA_MEMWB!=0) & (state==RUN).
- Forwarding register, updated on each rising edge:
  - FWD_VALID <= RF_WE_OUT; FWD_WA/FWD_WD <= RF_WA/RF_WD when RF_WE_OUT=1.
  - When RF_WE_OUT=0, FWD_WA/FWD_WD hold their previous values.
- Retire counter:
  - Increments by 1 when NUM_CHECK=1 and state==RUN, including the HALT instruction itself.
  - Saturates at 2^CNT_W-1; no wrap.
- FSM states RUN, DRAIN, HALTED:
  - RUN: HALT&NUM_CHECK=1 -> DRAIN, with drain counter loaded to HALT_DRAIN. If HALT_DRAIN=0, go directly to HALTED.
  - DRAIN: decrement the drain counter each cycle; at 1 -> HALTED. All writes and counting are suppressed (younger instructions are squashed).
  - HALTED: HALT_OUT=1; writes and counting suppressed; stays until RST.
  - HALT_OUT rises exactly HALT_DRAIN+1 cycles after the edge that sampled the HALT instruction.
- HALT with RF_WE=1 on the same instruction: no write, still counted.
- HALT with NUM_CHECK=0 (bubble) is ignored.
- RST in DRAIN or HALTED returns to RUN next edge, with counter and forwarding state cleared. RST has priority over all events in the same cycle.
- RWSrc=11: RF_WD=0. The write is still issued if enabled.

Decomposition:
- Shared package holds:
  - RWSrc encodings WB_ALU/WB_MEM/WB_LINK/WB_ZERO;
  - OPSrc encodings LD_W/LD_BS/LD_HS/LD_BU;
  - FSM state encodings.
- One sub-module is natural: load_extend (combinational, DATA_W data + 2-bit mode -> DATA_W result).
- The FSM, counter and forwarding register stay in the top module.

Test Plan:
- ALU write: RWSrc=00, ALUOUT=0x1234, WA=5, RF_WE=1, NUM_CHECK=1 -> RF_WE_OUT=1, RF_WD=0x1234 same cycle; next cycle FWD_VALID=1, FWD_WA=5, FWD_WD=0x1234; NUM_INST=1.
- Load extension: D_MEM_DI_OUT=0x0000_8F80.
  - OPSrc=01 -> RF_WD=0xFFFF_FF80.
  - OPSrc=10 -> RF_WD=0xFFFF_8F80.
  - OPSrc=11 -> RF_WD=0x0000_0080.
  - OPSrc=00 -> RF_WD=0x0000_8F80.
- r0 write and link: WA=0, RF_WE=1 -> RF_WE_OUT=0, FWD_VALID=0 next cycle, NUM_INST still increments. Then RWSrc=10, ADD_PC=0x40, WA=31 -> RF_WD=0x40.
- Halt drain (HALT_DRAIN=2): HALT&NUM_CHECK sampled at edge N, followed by valid writes.
  - HALT_OUT=1 after edge N+3.
  - No RF_WE_OUT after HALT.
  - NUM_INST frozen at its pre-halt value +1.
- Bubble and saturation:
  - HALT=1 with NUM_CHECK=0 -> no state change.
  - CNT_W=4, 17 retires -> NUM_INST=15.
- Reset mid-DRAIN: RST asserted in DRAIN -> next edge state RUN, HALT_OUT=0, NUM_INST=0, FWD_VALID=0; normal writes resume the following cycle.

Source files
------------

// File: rtl/wb_retire_unit_pkg.sv
// Shared encodings for the writeback/retire stage: writeback select, load
// extension mode and the halt-drain FSM states.
package wb_retire_unit_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10,
    WB_ZERO = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    LD_W  = 2'b00,
    LD_BS = 2'b01,
    LD_HS = 2'b10,
    LD_BU = 2'b11
  } ld_mode_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

endpackage

// File: rtl/wb_retire_unit_load_extend.sv
// Load-data extension: passes the word through, or sign/zero-extends the low
// byte or halfword of the raw load data.
module wb_retire_unit_load_extend
  import wb_retire_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        mode_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (ld_mode_e'(mode_i))
      LD_W:    data_o = data_i;
      LD_BS:   data_o = {{(DATA_W-8){data_i[7]}}, data_i[7:0]};
      LD_HS:   data_o = {{(DATA_W-16){data_i[15]}}, data_i[15:0]};
      LD_BU:   data_o = {{(DATA_W-8){1'b0}}, data_i[7:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/wb_retire_unit.sv
// Writeback/retire stage: register-file write port, registered WB->ID
// forwarding entry, saturating retire counter and halt-drain FSM.
module wb_retire_unit
  import wb_retire_unit_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned HALT_DRAIN = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        RWSrc,
  input  logic [1:0]        OPSrc,
  input  logic              RF_WE,
  input  logic              NUM_CHECK,
  input  logic              HALT,
  input  logic [DATA_W-1:0] ALUOUT_MEMWB,
  input  logic [DATA_W-1:0] ADD_PC_MEMWB,
  input  logic [DATA_W-1:0] D_MEM_DI_OUT,
  input  logic [ADDR_W-1:0] WA_MEMWB,
  output logic              RF_WE_OUT,
  output logic [ADDR_W-1:0] RF_WA,
  output logic [DATA_W-1:0] RF_WD,
  output logic              FWD_VALID,
  output logic [ADDR_W-1:0] FWD_WA,
  output logic [DATA_W-1:0] FWD_WD,
  output logic [CNT_W-1:0]  NUM_INST,
  output logic              HALT_OUT
);

  localparam int unsigned DRN_W = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN + 1) : 1;

  state_e             state_q, state_d;
  logic [DRN_W-1:0]   drain_q, drain_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               halt_q, halt_d;
  logic               fwd_v_q, fwd_v_d;
  logic [ADDR_W-1:0]  fwd_wa_q, fwd_wa_d;
  logic [DATA_W-1:0]  fwd_wd_q, fwd_wd_d;

  logic [DATA_W-1:0]  ld_data;
  logic [DATA_W-1:0]  wd;
  logic               run;
  logic               we;

  wb_retire_unit_load_extend #(
    .DATA_W (DATA_W)
  ) u_load_extend (
    .data_i (D_MEM_DI_OUT),
    .mode_i (OPSrc),
    .data_o (ld_data)
  );

  always_comb begin
    wd = '0;
    case (wb_sel_e'(RWSrc))
      WB_ALU:  wd = ALUOUT_MEMWB;
      WB_MEM:  wd = ld_data;
      WB_LINK: wd = ADD_PC_MEMWB;
      default: wd = '0;
    endcase
  end

  assign run = (state_q == ST_RUN);
  assign we  = RF_WE & NUM_CHECK & ~HALT & (WA_MEMWB != '0) & run & ~RST;

  // A zero drain depth skips DRAIN entirely; HALT_OUT is registered off
  // HALTED, which supplies the final cycle of latency.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_RUN: begin
        if (NUM_CHECK && HALT) begin
          if (HALT_DRAIN == 0) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_DRAIN;
            drain_d = DRN_W'(HALT_DRAIN);
          end
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q - DRN_W'(1);
        if (drain_q <= DRN_W'(1)) state_d = ST_HALTED;
      end
      default: state_d = ST_HALTED;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    halt_d   = (state_q == ST_HALTED);
    fwd_v_d  = we;
    fwd_wa_d = fwd_wa_q;
    fwd_wd_d = fwd_wd_q;
    if (NUM_CHECK && run && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    if (we) begin
      fwd_wa_d = WA_MEMWB;
      fwd_wd_d = wd;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_RUN;
      drain_q  <= '0;
      cnt_q    <= '0;
      halt_q   <= 1'b0;
      fwd_v_q  <= 1'b0;
      fwd_wa_q <= '0;
      fwd_wd_q <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      cnt_q    <= cnt_d;
      halt_q   <= halt_d;
      fwd_v_q  <= fwd_v_d;
      fwd_wa_q <= fwd_wa_d;
      fwd_wd_q <= fwd_wd_d;
    end
  end

  assign RF_WE_OUT = we;
  assign RF_WA     = WA_MEMWB;
  assign RF_WD     = wd;
  assign FWD_VALID = fwd_v_q;
  assign FWD_WA    = fwd_wa_q;
  assign FWD_WD    = fwd_wd_q;
  assign NUM_INST  = cnt_q;
  assign HALT_OUT  = halt_q;

endmodule

// File: tb/tb_wb_retire_unit.sv
// Scoreboard bench for wb_retire_unit: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_wb_retire_unit;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned HALT_DRAIN = 2;

  logic              CLK = 1'b0;
  logic              RST;
  logic [1:0]        RWSrc, OPSrc;
  logic              RF_WE, NUM_CHECK, HALT;
  logic [DATA_W-1:0] ALUOUT_MEMWB, ADD_PC_MEMWB, D_MEM_DI_OUT;
  logic [ADDR_W-1:0] WA_MEMWB;
  logic              RF_WE_OUT;
  logic [ADDR_W-1:0] RF_WA;
  logic [DATA_W-1:0] RF_WD;
  logic              FWD_VALID;
  logic [ADDR_W-1:0] FWD_WA;
  logic [DATA_W-1:0] FWD_WD;
  logic [CNT_W-1:0]  NUM_INST;
  logic              HALT_OUT;

  wb_retire_unit #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .CNT_W      (CNT_W),
    .HALT_DRAIN (HALT_DRAIN)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RWSrc        (RWSrc),
    .OPSrc        (OPSrc),
    .RF_WE        (RF_WE),
    .NUM_CHECK    (NUM_CHECK),
    .HALT         (HALT),
    .ALUOUT_MEMWB (ALUOUT_MEMWB),
    .ADD_PC_MEMWB (ADD_PC_MEMWB),
    .D_MEM_DI_OUT (D_MEM_DI_OUT),
    .WA_MEMWB     (WA_MEMWB),
    .RF_WE_OUT    (RF_WE_OUT),
    .RF_WA        (RF_WA),
    .RF_WD        (RF_WD),
    .FWD_VALID    (FWD_VALID),
    .FWD_WA       (FWD_WA),
    .FWD_WD       (FWD_WD),
    .NUM_INST     (NUM_INST),
    .HALT_OUT     (HALT_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              fv;
    logic [ADDR_W-1:0] fwa;
    logic [DATA_W-1:0] fwd;
    logic [CNT_W-1:0]  cnt;
    logic              ho;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state (behavioural, tracks edges since the halt retired)
  logic              m_fv;
  logic [ADDR_W-1:0] m_fwa;
  logic [DATA_W-1:0] m_fwd;
  int                m_cnt;
  logic              m_seen;
  int                m_age;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("RF_WE_OUT", DATA_W'(RF_WE_OUT), DATA_W'(e.we));
      check("RF_WA",     DATA_W'(RF_WA),     DATA_W'(e.wa));
      check("RF_WD",     RF_WD,              e.wd);
      check("FWD_VALID", DATA_W'(FWD_VALID), DATA_W'(e.fv));
      check("FWD_WA",    DATA_W'(FWD_WA),    DATA_W'(e.fwa));
      check("FWD_WD",    FWD_WD,             e.fwd);
      check("NUM_INST",  DATA_W'(NUM_INST),  DATA_W'(e.cnt));
      check("HALT_OUT",  DATA_W'(HALT_OUT),  DATA_W'(e.ho));
    end
  end

  // One cycle: drive inputs, push expectation, advance model past the edge.
  task automatic drive(input logic rst, input logic [1:0] rws, input logic [1:0] ops,
                       input logic we, input logic nc, input logic halt,
                       input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] pc,
                       input logic [DATA_W-1:0] mem, input logic [ADDR_W-1:0] wa,
                       input logic [DATA_W-1:0] exp_wd);
    exp_t e;
    logic exp_we;
    RST = rst; RWSrc = rws; OPSrc = ops; RF_WE = we; NUM_CHECK = nc; HALT = halt;
    ALUOUT_MEMWB = alu; ADD_PC_MEMWB = pc; D_MEM_DI_OUT = mem; WA_MEMWB = wa;
    exp_we = !rst && we && nc && !halt && (wa != 0) && !m_seen;
    e.we = exp_we; e.wa = wa; e.wd = exp_wd;
    e.fv = m_fv; e.fwa = m_fwa; e.fwd = m_fwd;
    e.cnt = CNT_W'(m_cnt);
    e.ho = m_seen && (m_age >= int'(HALT_DRAIN) + 1);
    q.push_back(e);
    @(posedge CLK);
    #1;
    if (rst) begin
      m_fv = 1'b0; m_fwa = '0; m_fwd = '0; m_cnt = 0; m_seen = 1'b0; m_age = 0;
    end else begin
      m_fv = exp_we;
      if (exp_we) begin m_fwa = wa; m_fwd = exp_wd; end
      if (nc && !m_seen && m_cnt < 15) m_cnt = m_cnt + 1;
      if (m_seen) m_age = m_age + 1;
      else if (nc && halt) begin m_seen = 1'b1; m_age = 0; end
    end
  endtask

  initial begin
    RST = 1'b1; RWSrc = '0; OPSrc = '0; RF_WE = 1'b0; NUM_CHECK = 1'b0; HALT = 1'b0;
    ALUOUT_MEMWB = '0; ADD_PC_MEMWB = '0; D_MEM_DI_OUT = '0; WA_MEMWB = '0;
    m_fv = 1'b0; m_fwa = '0; m_fwd = '0; m_cnt = 0; m_seen = 1'b0; m_age = 0;
    repeat (2) @(posedge CLK);
    #1;

    // Reset state; write enable forced low while RST is high
    drive(1, 2'b00, 2'b00, 1, 1, 0, 32'h1234, 0, 0, 5'd5, 32'h1234);
    // ALU write
    drive(0, 2'b00, 2'b00, 1, 1, 0, 32'h1234, 0, 0, 5'd5, 32'h1234);
    // Load extension
    drive(0, 2'b01, 2'b01, 1, 1, 0, 0, 0, 32'h0000_8F80, 5'd6, 32'hFFFF_FF80);
    drive(0, 2'b01, 2'b10, 1, 1, 0, 0, 0, 32'h0000_8F80, 5'd7, 32'hFFFF_8F80);
    drive(0, 2'b01, 2'b11, 1, 1, 0, 0, 0, 32'h0000_8F80, 5'd8, 32'h0000_0080);
    drive(0, 2'b01, 2'b00, 1, 1, 0, 0, 0, 32'h0000_8F80, 5'd9, 32'h0000_8F80);
    // r0 write suppressed, still retired; then link; then zero select
    drive(0, 2'b00, 2'b00, 1, 1, 0, 32'hDEAD, 0, 0, 5'd0, 32'hDEAD);
    drive(0, 2'b10, 2'b00, 1, 1, 0, 32'h77, 32'h40, 0, 5'd31, 32'h40);
    drive(0, 2'b11, 2'b00, 1, 1, 0, 32'h55, 32'h44, 0, 5'd3, 32'h0);
    // Bubbles, including a HALT bubble that must be ignored
    drive(0, 2'b00, 2'b00, 1, 0, 1, 32'h99, 0, 0, 5'd4, 32'h99);
    drive(0, 2'b00, 2'b00, 1, 0, 0, 32'h98, 0, 0, 5'd4, 32'h98);
    // Saturation: 8 retired so far, 9 more pushes the 4-bit count past 15
    for (int i = 0; i < 9; i++)
      drive(0, 2'b00, 2'b00, 1, 1, 0, 32'h100 + i, 0, 0, 5'(i + 1), 32'h100 + i);

    // Halt drain from a fresh count
    drive(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0);
    for (int i = 0; i < 3; i++)
      drive(0, 2'b00, 2'b00, 1, 1, 0, 32'h200 + i, 0, 0, 5'(i + 10), 32'h200 + i);
    drive(0, 2'b00, 2'b00, 1, 1, 1, 32'h2FF, 0, 0, 5'd20, 32'h2FF);
    for (int i = 0; i < 6; i++)
      drive(0, 2'b00, 2'b00, 1, 1, 0, 32'h300 + i, 0, 0, 5'(i + 12), 32'h300 + i);

    // Reset mid-DRAIN, then normal writes resume
    drive(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0);
    drive(0, 2'b00, 2'b00, 1, 1, 0, 32'h400, 0, 0, 5'd1, 32'h400);
    drive(0, 2'b00, 2'b00, 1, 1, 1, 32'h401, 0, 0, 5'd2, 32'h401);
    drive(0, 2'b00, 2'b00, 1, 1, 0, 32'h402, 0, 0, 5'd3, 32'h402);
    drive(1, 2'b00, 2'b00, 1, 1, 0, 32'h403, 0, 0, 5'd4, 32'h403);
    drive(0, 2'b00, 2'b00, 1, 1, 0, 32'h404, 0, 0, 5'd5, 32'h404);
    drive(0, 2'b00, 2'b00, 1, 1, 0, 32'h405, 0, 0, 5'd6, 32'h405);
    drive(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0);

    repeat (3) @(negedge CLK);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
